// File: rtl/user_obi_mgr_arbiter_pkg.sv
// Shared types for the user-domain OBI manager arbiter.
// Bus structs mirror the Croc manager-side OBI configuration.
package user_obi_mgr_arbiter_pkg;

    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned IdWidth    = 1;
    localparam int unsigned NumUserMgr = 2;

    typedef enum logic [0:0] {
        UserMgr0 = 1'b0,
        UserMgr1 = 1'b1
    } user_mgr_e;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
        logic                   a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
        logic                 r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } mgr_obi_rsp_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_obi_mgr_arbiter_fifo.sv
// Non-fall-through FIFO holding the requester index of each granted
// transaction so responses can be routed back in order.
module user_obi_mgr_arbiter_fifo
    import user_obi_mgr_arbiter_pkg::*;
#(
    parameter int unsigned DataWidth = 1,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    output logic                 full_o,
    output logic                 empty_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 push_i,
    output logic [DataWidth-1:0] data_o,
    input  logic                 pop_i
);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;

    logic [DataWidth-1:0] mem_q [Depth];
    ptr_t                 wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 do_push, do_pop;
    logic                 unused_tm;

    assign unused_tm = testmode_i;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/user_obi_mgr_arbiter.sv
// Round-robin arbiter sharing the user-domain OBI manager port between
// NumReq managers, with in-order response routing via an index FIFO.
module user_obi_mgr_arbiter
    import user_obi_mgr_arbiter_pkg::*;
#(
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t,
    parameter int unsigned NumReq      = NumUserMgr,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     testmode_i,
    input  obi_req_t sbr_req_i [NumReq],
    output obi_rsp_t sbr_rsp_o [NumReq],
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i
);
    localparam int unsigned IdxW = idx_width(NumReq);

    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_q, rr_d, lidx_q, lidx_d;
    idx_t sel, head;
    logic lock_q, lock_d;
    logic full, empty, hs, pop;

    // Reverse scan so the candidate closest to rr_q is written last.
    always_comb begin
        sel = lock_q ? lidx_q : rr_q;
        if (!lock_q) begin
            for (int k = int'(NumReq) - 1; k >= 0; k--) begin
                if (sbr_req_i[(int'(rr_q) + k) % int'(NumReq)].req) begin
                    sel = idx_t'((int'(rr_q) + k) % int'(NumReq));
                end
            end
        end
    end

    always_comb begin
        mgr_req_o     = sbr_req_i[sel];
        mgr_req_o.req = sbr_req_i[sel].req & ~full;
    end

    assign hs  = mgr_req_o.req & mgr_rsp_i.gnt;
    assign pop = mgr_rsp_i.rvalid & ~empty;

    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (hs) begin
            lock_d = 1'b0;
            rr_d   = (sel == idx_t'(NumReq - 1)) ? '0 : sel + 1'b1;
        end else if (mgr_req_o.req) begin
            lock_d = 1'b1;
            lidx_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            sbr_rsp_o[i]        = mgr_rsp_i;
            sbr_rsp_o[i].gnt    = hs && (sel == idx_t'(i));
            sbr_rsp_o[i].rvalid = pop && (head == idx_t'(i));
        end
    end

    user_obi_mgr_arbiter_fifo #(
        .DataWidth (IdxW),
        .Depth     (NumMaxTrans)
    ) i_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (testmode_i),
        .full_o     (full),
        .empty_o    (empty),
        .data_i     (sel),
        .push_i     (hs),
        .data_o     (head),
        .pop_i      (pop)
    );

    // A response with nothing outstanding has no owner and is dropped.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        mgr_rsp_i.rvalid |-> !empty);

endmodule

// File: tb/tb_user_obi_mgr_arbiter.sv
// Scoreboard bench for the user OBI manager arbiter: directed stimulus
// queues expected grants/responses, a negedge monitor checks them.
module tb_user_obi_mgr_arbiter;
    import user_obi_mgr_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         testmode = 1'b0;
    mgr_obi_req_t sbr_req [NumUserMgr];
    mgr_obi_rsp_t sbr_rsp [NumUserMgr];
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp;

    always #5 clk = ~clk;

    user_obi_mgr_arbiter #(
        .obi_req_t   (mgr_obi_req_t),
        .obi_rsp_t   (mgr_obi_rsp_t),
        .NumReq      (2),
        .NumMaxTrans (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .testmode_i (testmode),
        .sbr_req_i  (sbr_req),
        .sbr_rsp_o  (sbr_rsp),
        .mgr_req_o  (mgr_req),
        .mgr_rsp_i  (mgr_rsp)
    );

    typedef struct {
        int          port;
        logic [31:0] addr;
    } gnt_exp_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];
    int       checks = 0;
    int       errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(string name);
        chk({name, "_mreq"}, 32'(mgr_req.req), 32'd0);
        chk({name, "_gnt0"}, 32'(sbr_rsp[0].gnt), 32'd0);
        chk({name, "_gnt1"}, 32'(sbr_rsp[1].gnt), 32'd0);
        chk({name, "_rv0"}, 32'(sbr_rsp[0].rvalid), 32'd0);
        chk({name, "_rv1"}, 32'(sbr_rsp[1].rvalid), 32'd0);
    endtask

    task automatic drive(logic r0, logic r1, logic g, logic rv,
                         logic [31:0] rd, logic er);
        sbr_req[0].req    = r0;
        sbr_req[1].req    = r1;
        mgr_rsp.gnt       = g;
        mgr_rsp.rvalid    = rv;
        mgr_rsp.r.rdata   = rd;
        mgr_rsp.r.err     = er;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(logic [31:0] a0, logic [31:0] a1);
        sbr_req[0].a.addr = a0;
        sbr_req[1].a.addr = a1;
    endtask

    // Monitor: every gnt/rvalid the DUT presents is matched to the queue.
    always @(negedge clk) begin
        gnt_exp_t ge;
        rsp_exp_t re;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (sbr_rsp[i].gnt) begin
                    if (gq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL gnt_unexpected: port %0d got gnt, none expected", i);
                    end else begin
                        ge = gq.pop_front();
                        chk("gnt_port", 32'(i), 32'(ge.port));
                        chk("gnt_addr", mgr_req.a.addr, ge.addr);
                    end
                end
                if (sbr_rsp[i].rvalid) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rvalid_unexpected: port %0d got rvalid, none expected", i);
                    end else begin
                        re = rq.pop_front();
                        chk("rsp_port", 32'(i), 32'(re.port));
                        chk("rsp_rdata", sbr_rsp[i].r.rdata, re.rdata);
                        chk("rsp_err", 32'(sbr_rsp[i].r.err), 32'(re.err));
                    end
                end
            end
        end
    end

    initial begin
        sbr_req[0] = '0;
        sbr_req[1] = '0;
        mgr_rsp    = '0;
        set_addr(32'h1000_0000, 32'h1000_0100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, no requests
        @(negedge clk);
        chk_idle("reset");

        // Both requesting, gnt always high: alternation 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            next();
            drive(1, 1, 1, k > 0, 32'hD000_0000 + 32'(k - 1), 0);
            gq.push_back('{k % 2, (k % 2) ? 32'h1000_0100 : 32'h1000_0000});
            if (k > 0) rq.push_back('{(k - 1) % 2, 32'hD000_0000 + 32'(k - 1), 1'b0});
        end
        next();
        drive(0, 0, 0, 1, 32'hD000_0003, 0);
        rq.push_back('{1, 32'hD000_0003, 1'b0});
        next();
        drive(0, 0, 0, 0, 0, 0);

        // Req1 stalled by gnt=0, req0 joins: address must not move
        set_addr(32'h3000_0000, 32'h2000_0010);
        for (int k = 0; k < 3; k++) begin
            next();
            drive(k >= 1, 1, 0, 0, 0, 0);
            @(negedge clk);
            chk("stall_addr", mgr_req.a.addr, 32'h2000_0010);
            chk("stall_req", 32'(mgr_req.req), 32'd1);
        end
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h2000_0010});
        next();
        drive(1, 0, 1, 1, 32'h1111_0001, 0);
        gq.push_back('{0, 32'h3000_0000});
        rq.push_back('{1, 32'h1111_0001, 1'b0});
        next();
        drive(0, 0, 0, 1, 32'h1111_0002, 0);
        rq.push_back('{0, 32'h1111_0002, 1'b0});

        // Outstanding limit: third request waits for a pop, then one cycle
        set_addr(32'h4000_0000, 32'h4000_0100);
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h4000_0100});
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{0, 32'h4000_0000});
        for (int k = 0; k < 2; k++) begin
            next();
            drive(1, 1, 1, 0, 0, 0);
            @(negedge clk);
            chk("full_req_held", 32'(mgr_req.req), 32'd0);
        end
        next();
        drive(1, 1, 1, 1, 32'h4444_0001, 0);
        rq.push_back('{1, 32'h4444_0001, 1'b0});
        @(negedge clk);
        chk("pop_cycle_no_gnt", 32'(mgr_req.req), 32'd0);
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h4000_0100});
        @(negedge clk);
        chk("after_pop_req", 32'(mgr_req.req), 32'd1);
        next();
        drive(0, 0, 0, 1, 32'h4444_0002, 0);
        rq.push_back('{0, 32'h4444_0002, 1'b0});
        next();
        drive(0, 0, 0, 1, 32'h4444_0003, 0);
        rq.push_back('{1, 32'h4444_0003, 1'b0});

        // Interleaved responses, error on the second
        set_addr(32'h5000_0000, 32'h5000_0100);
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{0, 32'h5000_0000});
        next();
        drive(0, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h5000_0100});
        next();
        drive(0, 0, 0, 1, 32'hA5A5_0001, 0);
        rq.push_back('{0, 32'hA5A5_0001, 1'b0});
        next();
        drive(0, 0, 0, 1, 32'hA5A5_0002, 1);
        rq.push_back('{1, 32'hA5A5_0002, 1'b1});
        @(negedge clk);
        chk("port0_rvalid_gated", 32'(sbr_rsp[0].rvalid), 32'd0);
        chk("port0_rdata_bcast", sbr_rsp[0].r.rdata, 32'hA5A5_0002);

        // Reset with two outstanding, rr_ptr left at 1
        set_addr(32'h6000_0000, 32'h6000_0100);
        next();
        drive(0, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h6000_0100});
        next();
        drive(1, 0, 1, 0, 0, 0);
        gq.push_back('{0, 32'h6000_0000});
        next();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{0, 32'h6000_0000});
        next();
        drive(1, 1, 1, 0, 0, 0);
        gq.push_back('{1, 32'h6000_0100});
        next();
        drive(0, 0, 0, 1, 32'h6666_0001, 0);
        rq.push_back('{0, 32'h6666_0001, 1'b0});
        next();
        drive(0, 0, 0, 1, 32'h6666_0002, 0);
        rq.push_back('{1, 32'h6666_0002, 1'b0});
        next();
        drive(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
